// File: rtl/nn_sequencer.sv
// nn_sequencer: evaluates the 2-3-1 unsigned network by time-multiplexing one multiply-accumulate unit.
// Latency: done pulses 10 cycles after an accepted start; one inference per 10 cycles, back-to-back allowed.
// Backpressure: none; start and cfg_we are dropped while busy (no queueing).
// Ports: clk, rst (synchronous, active-high); cfg_we/cfg_addr/cfg_data program weights (0-8) and
//        biases (9-12) while idle; start/x1/x2 launch a run; busy/done report progress;
//        y is the registered network output, h_out = {h3,h2,h1} from the last completed run.
module nn_sequencer #(
  parameter int XW = 2,
  parameter int BW = 4,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [BW-1:0]   cfg_data,
  input  logic            start,
  input  logic [XW-1:0]   x1,
  input  logic [XW-1:0]   x2,
  output logic            busy,
  output logic            done,
  output logic [XW-1:0]   y,
  output logic [3*XW-1:0] h_out
);

  typedef enum logic [1:0] {IDLE, HID, OUT} state_t;

  state_t          state, state_nx;
  logic [1:0]      j_r, j_nx;        // hidden neuron index
  logic [1:0]      k_r, k_nx;        // term index within the current dot product
  logic [AW-1:0]   acc_r, acc_nx;
  logic [XW-1:0]   x1_r, x1_nx, x2_r, x2_nx;
  logic [XW-1:0]   w_r [0:8];        // w11,w12,w13,w21,w22,w23,w01,w02,w03
  logic [BW-1:0]   b_r [0:3];        // b1,b2,b3,bo
  logic [XW-1:0]   h_r [0:2];
  logic [XW-1:0]   h_nx [0:2];
  logic [XW-1:0]   y_r, y_nx;
  logic [3*XW-1:0] h_out_r, h_out_nx;
  logic            done_r, done_nx;

  logic [XW-1:0]   op_a, op_w;
  logic [AW-1:0]   mac;
  logic [BW-1:0]   b1_eff;
  logic [3:0]      b_idx;

  function automatic logic [XW-1:0] sat2(input logic [AW-1:0] a);
    if (a > AW'({XW{1'b1}})) return {XW{1'b1}};
    else return a[XW-1:0];
  endfunction

  // A write to b1 in the start cycle must be seen by the run it launches,
  // and b1 is the only register consumed on that same edge.
  assign b1_eff = (cfg_we && cfg_addr == 4'd9) ? cfg_data : b_r[0];
  assign b_idx  = cfg_addr - 4'd9;

  // Shared MAC operand selection
  always_comb begin
    op_a = '0;
    op_w = '0;
    if (state == OUT) begin
      op_a = h_r[k_r];
      op_w = w_r[4'd6 + {2'b00, k_r}];
    end else if (k_r == 2'd0) begin
      op_a = x1_r;
      op_w = w_r[{2'b00, j_r}];
    end else begin
      op_a = x2_r;
      op_w = w_r[4'd3 + {2'b00, j_r}];
    end
  end

  assign mac = acc_r + AW'(op_a) * AW'(op_w);

  // Next-state and datapath control
  always_comb begin
    state_nx = state;
    j_nx     = j_r;
    k_nx     = k_r;
    acc_nx   = acc_r;
    x1_nx    = x1_r;
    x2_nx    = x2_r;
    h_nx     = h_r;
    y_nx     = y_r;
    h_out_nx = h_out_r;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          x1_nx    = x1;
          x2_nx    = x2;
          acc_nx   = AW'(b1_eff);
          j_nx     = 2'd0;
          k_nx     = 2'd0;
          state_nx = HID;
        end
      end
      HID: begin
        if (k_r == 2'd0) begin
          acc_nx = mac;
          k_nx   = 2'd1;
        end else begin
          h_nx[j_r] = sat2(mac);
          k_nx      = 2'd0;
          if (j_r == 2'd2) begin
            acc_nx   = AW'(b_r[3]);
            j_nx     = 2'd0;
            state_nx = OUT;
          end else begin
            acc_nx = AW'(b_r[j_r + 2'd1]);
            j_nx   = j_r + 2'd1;
          end
        end
      end
      OUT: begin
        acc_nx = mac;
        if (k_r == 2'd2) begin
          // Results become visible together with done; h_out tracks the completed run only.
          y_nx     = sat2(mac);
          h_out_nx = {h_r[2], h_r[1], h_r[0]};
          done_nx  = 1'b1;
          k_nx     = 2'd0;
          state_nx = IDLE;
        end else begin
          k_nx = k_r + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      j_r     <= '0;
      k_r     <= '0;
      acc_r   <= '0;
      x1_r    <= '0;
      x2_r    <= '0;
      y_r     <= '0;
      h_out_r <= '0;
      done_r  <= 1'b0;
      for (int i = 0; i < 9; i++) w_r[i] <= '0;
      for (int i = 0; i < 4; i++) b_r[i] <= '0;
      for (int i = 0; i < 3; i++) h_r[i] <= '0;
    end else begin
      state   <= state_nx;
      j_r     <= j_nx;
      k_r     <= k_nx;
      acc_r   <= acc_nx;
      x1_r    <= x1_nx;
      x2_r    <= x2_nx;
      y_r     <= y_nx;
      h_out_r <= h_out_nx;
      done_r  <= done_nx;
      for (int i = 0; i < 3; i++) h_r[i] <= h_nx[i];
      // Configuration is frozen for the whole run; addresses 13-15 are unmapped.
      if (cfg_we && state == IDLE) begin
        if (cfg_addr <= 4'd8) w_r[cfg_addr] <= cfg_data[XW-1:0];
        else if (cfg_addr <= 4'd12) b_r[b_idx[1:0]] <= cfg_data;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign done  = done_r;
  assign y     = y_r;
  assign h_out = h_out_r;

endmodule

// File: tb/tb_nn_sequencer.sv
module tb_nn_sequencer;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start, busy, done;
  logic [3:0] cfg_addr, cfg_data;
  logic [1:0] x1, x2, y;
  logic [5:0] h_out;

  int checks = 0;
  int failures = 0;
  int m_cfg [13];   // reference copy of the configuration, in address order

  nn_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .x1(x1), .x2(x2), .busy(busy), .done(done), .y(y), .h_out(h_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:12][3:0] cfg;   // address 0 first
    logic [1:0]       xa;
    logic [1:0]       xb;
    logic [1:0]       ey;
    logic [5:0]       eh;
  } vec_t;
  vec_t vecs [6];

  logic [1:0] ry, y1, y2;
  logic [5:0] rh;
  int tbad, nd, d1, d2, holes;
  int xa, xb, my, mh, nw, wa, wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int sat2(input int a);
    return (a > 3) ? 3 : a;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 13; i++) m_cfg[i] = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    if (a <= 8) m_cfg[a] = d & 3;
    else if (a <= 12) m_cfg[a] = d;
  endfunction

  // Network evaluated directly from the arithmetic definition.
  function automatic void model_eval(input int ia, input int ib, output int oy, output int oh);
    int hh [3];
    int acc;
    for (int j = 0; j < 3; j++) begin
      acc = m_cfg[9 + j] + ia * m_cfg[j] + ib * m_cfg[3 + j];
      hh[j] = sat2(acc);
    end
    acc = m_cfg[12] + hh[0] * m_cfg[6] + hh[1] * m_cfg[7] + hh[2] * m_cfg[8];
    oy = sat2(acc);
    oh = hh[2] * 16 + hh[1] * 4 + hh[0];
  endfunction

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 4'(d);
    tick();
    cfg_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic load_vec(input int i);
    for (int a = 0; a < 13; a++) cfg_wr(a, int'(vecs[i].cfg[a]));
  endtask

  // One run: start in cycle T, busy expected T+1..T+9, done only at T+10.
  task automatic do_run(input logic [1:0] a, input logic [1:0] b,
                        output logic [1:0] oy, output logic [5:0] oh, output int bad);
    start = 1'b1;
    x1 = a;
    x2 = b;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    bad = 0;
    for (int c = 1; c <= 9; c++) begin
      x1 = 2'($urandom_range(0, 3));
      x2 = 2'($urandom_range(0, 3));
      if (!busy || done) bad++;
      tick();
    end
    if (!done || busy) bad++;
    oy = y;
    oh = h_out;
    tick();
    if (done) bad++;
  endtask

  // Run with perturbations at cycle offsets sc (start), wc (write w01=0), rc (reset).
  task automatic monitor(input logic [1:0] a, input logic [1:0] b, input int n,
                         input int sc, input int wc, input int rc,
                         output int ond, output int od1, output int od2,
                         output logic [1:0] oy1, output logic [1:0] oy2, output int oholes);
    start = 1'b1;
    x1 = a;
    x2 = b;
    tick();
    ond = 0; od1 = -1; od2 = -1; oy1 = 2'd0; oy2 = 2'd0; oholes = 0;
    for (int c = 1; c <= n; c++) begin
      start = (c == sc);
      x1 = (c == sc) ? a : 2'($urandom_range(0, 3));
      x2 = (c == sc) ? b : 2'($urandom_range(0, 3));
      cfg_we = (c == wc);
      cfg_addr = 4'd6;
      cfg_data = 4'd0;
      rst = (c == rc);
      if (done) begin
        ond++;
        if (ond == 1) begin od1 = c; oy1 = y; end
        else begin od2 = c; oy2 = y; end
      end
      if (c >= 11 && c <= 19 && !busy) oholes++;
      tick();
    end
    start = 1'b0;
    cfg_we = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; x1 = '0; x2 = '0;

    //            w11  w12  w13  w21  w22  w23  w01  w02  w03  b1    b2    b3    bo
    vecs[0] = '{cfg: {4'd1,4'd0,4'd3,4'd1,4'd0,4'd2,4'd1,4'd3,4'd0,4'd0, 4'd1, 4'd3, 4'd0},
                xa: 2'd0, xb: 2'd1, ey: 2'd3, eh: 6'h35};
    vecs[1] = '{cfg: '0, xa: 2'd3, xb: 2'd3, ey: 2'd0, eh: 6'h00};
    vecs[2] = '{cfg: {4'd1,4'd0,4'd0,4'd0,4'd0,4'd0,4'd1,4'd0,4'd0,4'd0, 4'd0, 4'd0, 4'd0},
                xa: 2'd1, xb: 2'd0, ey: 2'd1, eh: 6'h01};
    vecs[3] = '{cfg: {4'd3,4'd3,4'd3,4'd3,4'd3,4'd3,4'd3,4'd3,4'd3,4'd15,4'd15,4'd15,4'd15},
                xa: 2'd3, xb: 2'd3, ey: 2'd3, eh: 6'h3F};
    vecs[4] = '{cfg: {4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd2, 4'd0, 4'd1, 4'd1},
                xa: 2'd2, xb: 2'd1, ey: 2'd1, eh: 6'h12};
    vecs[5] = '{cfg: {4'd0,4'd2,4'd0,4'd0,4'd1,4'd0,4'd0,4'd1,4'd0,4'd0, 4'd0, 4'd0, 4'd0},
                xa: 2'd1, xb: 2'd0, ey: 2'd2, eh: 6'h08};

    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    check("reset_y", y, 0);
    check("reset_h", h_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      load_vec(i);
      do_run(vecs[i].xa, vecs[i].xb, ry, rh, tbad);
      check($sformatf("vec%0d_y", i), ry, vecs[i].ey);
      check($sformatf("vec%0d_h", i), rh, vecs[i].eh);
      check($sformatf("vec%0d_timing", i), tbad, 0);
    end

    // b1 written in the start cycle is used by that run
    load_vec(2);
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 4'd2;
    model_write(9, 2);
    do_run(2'd0, 2'd0, ry, rh, tbad);
    check("same_cycle_b1_y", ry, 2);
    check("same_cycle_b1_h", rh, 2);
    cfg_wr(9, 0);

    // start at T+4 and w01 write at T+5 are both ignored
    load_vec(0);
    monitor(2'd0, 2'd1, 22, 4, 5, 0, nd, d1, d2, y1, y2, holes);
    check("hazard_done_count", nd, 1);
    check("hazard_done_cycle", d1, 10);
    check("hazard_y", y1, 3);
    check("hazard_h", h_out, 6'h35);
    // With w02 cleared, y depends only on w01: old weight 1 gives y=1
    cfg_wr(7, 0);
    do_run(2'd0, 2'd1, ry, rh, tbad);
    check("readback_y", ry, 1);
    check("readback_h", rh, 6'h35);
    cfg_wr(7, 3);

    // Reset at T+6 aborts the run and clears config
    monitor(2'd0, 2'd1, 16, 0, 0, 6, nd, d1, d2, y1, y2, holes);
    model_reset();
    check("midreset_done_count", nd, 0);
    check("midreset_y", y, 0);
    check("midreset_h", h_out, 0);
    check("midreset_busy", busy, 0);
    do_run(2'd3, 2'd3, ry, rh, tbad);
    check("after_reset_y", ry, 0);
    check("after_reset_h", rh, 0);

    // Back-to-back: start in the done cycle
    load_vec(0);
    monitor(2'd0, 2'd1, 22, 10, 0, 0, nd, d1, d2, y1, y2, holes);
    check("b2b_done_count", nd, 2);
    check("b2b_done1_cycle", d1, 10);
    check("b2b_done2_cycle", d2, 20);
    check("b2b_y1", y1, 3);
    check("b2b_y2", y2, 3);
    check("b2b_busy_holes", holes, 0);

    // Randomized configuration and inputs against the reference model
    for (int r = 0; r < 40; r++) begin
      nw = $urandom_range(0, 6);
      for (int k = 0; k < nw; k++) begin
        wa = $urandom_range(0, 15);
        wd = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
        cfg_wr(wa, wd);
      end
      xa = $urandom_range(0, 3);
      xb = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        wa = $urandom_range(0, 15);
        wd = $urandom_range(0, 15);
        cfg_we = 1'b1; cfg_addr = 4'(wa); cfg_data = 4'(wd);
        model_write(wa, wd);
      end
      model_eval(xa, xb, my, mh);
      do_run(2'(xa), 2'(xb), ry, rh, tbad);
      check($sformatf("rnd%0d_y", r), ry, my);
      check($sformatf("rnd%0d_h", r), rh, mh);
      check($sformatf("rnd%0d_timing", r), tbad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_sequencer.md
# nn_sequencer

Sequential controller for the team's 2-input, 3-hidden-neuron, 1-output network. It holds the weight/bias set in a small configuration register file and evaluates one inference per `start` by time-multiplexing a single multiply-accumulate unit, instead of instantiating nine multipliers. It sits between the host configuration path and the consumer of the 2-bit network output `y`, and replaces the fully combinational evaluator where area matters.

## Interface
Parameters:
- `XW`, 2: width of inputs, weights and hidden activations.
- `BW`, 4: bias width.
- `AW`, 6: accumulator width. The worst case is 15+3·3·3=42, so no overflow is possible.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_addr`  in  4  register index (map below).
- `cfg_data`  in  4  write data; weights use `[1:0]`, biases use `[3:0]`.
- `start`  in  1  request one inference.
- `x1`, `x2`  in  2 each  network inputs, sampled in the start cycle.
- `busy`  out  1  evaluation in progress.
- `done`  out  1  one-cycle completion pulse.
- `y`  out  2  network output; registered, holds between runs.
- `h_out`  out  6  `{h3,h2,h1}` hidden activations from the last run, for debug.

## Operation
- **Config map:**
  - 0–2: `w11`, `w12`, `w13`; 3–5: `w21`, `w22`, `w23` (input→hidden j).
  - 6–8: `w01`, `w02`, `w03` (hidden→out).
  - 9–11: `b1`–`b3`; 12: `bo`.
  - 13–15: writes ignored.
- **Arithmetic:** all unsigned.
  - Hidden: `acc_j = bj + x1·w1j + x2·w2j`, then `hj = sat2(acc_j)`.
  - Output: `y = sat2(bo + h1·w01 + h2·w02 + h3·w03)`.
  - `sat2(a)` = 3 if a>3, else a[1:0].
- **FSM states:**
  - `IDLE`:
    - `start`=1 latches x1/x2, loads acc←b1 and moves to `HID`.
  - `HID`, with neuron index j 0..2 and term k 0..1:
    - Each cycle: acc += x_(k+1)·w_(k+1)j.
    - After k=1: capture hj, then either acc←b(j+1) for the next neuron, or, after j=2, acc←bo and go to `OUT`.
  - `OUT`, term k 0..2:
    - Each cycle: acc += h(k+1)·w0(k+1).
    - After k=2: y←sat2(acc), done←1, go to `IDLE`.
- **Input handling:**
  - Inputs, weights and biases are used from registers only; x1/x2 changes after the start cycle do not affect the run.
  - `start` while busy is ignored; there is no queueing.
  - `cfg_we` while busy is ignored; the register is not written. `cfg_we` in `IDLE` writes on that edge.
  - `cfg_we` and `start` in the same `IDLE` cycle: the write completes first, and the run uses the new value.
- **Reset:** forces `IDLE` and clears the following, including mid-run; any in-flight result is discarded and `done` is not pulsed:
  - all config registers to 0;
  - acc, h1–h3, y to 0;
  - busy=0, done=0.

## Timing
- Let T be the cycle in which `start`=1 is sampled in `IDLE`.
- `busy`=1 in cycles T+1 … T+9: 6 hidden MAC cycles, then 3 output MAC cycles.
- `y`, `h_out` update and `done`=1 in cycle T+10, for exactly one cycle. `busy`=0 in T+10.
- Latency from start to done is 10 cycles. Throughput is one inference per 10 cycles.
- Back-to-back runs: a `start` sampled in the `done` cycle (T+10) is accepted, giving the next `done` at T+20.
- Outputs `y`, `h_out` are held stable at all times except the completion edge and reset.
- Reset values: y=0, h_out=0, busy=0, done=0.

## Test plan
- **Reference vector.** Program w11=1, w12=0, w13=3, w21=1, w22=0, w23=2, w01=1, w02=3, w03=0, b1=0, b2=1, b3=3, bo=0. Then start with x1=0, x2=1.
  - Expect h_out={3,1,1}, since h3 saturates from 5.
  - Expect y=3, since the output saturates from 4.
  - Expect `done` exactly at T+10 and busy high for T+1…T+9.
- **Zero config.** After reset, start with x1=3, x2=3.
  - Expect y=0, h_out=0, done at T+10.
- **Single path.** Program w11=1 and w01=1, everything else 0. Start with x1=1, x2=0.
  - Expect h1=1 and y=1.
- **Hazards during a run.**
  - Pulse `start` at T+4: expect it to be ignored, with one `done` only.
  - Write `w01`=0 at T+5: expect no effect, y unchanged from the unperturbed run, and a readback run afterwards still shows the old weight behaviour.
- **Reset mid-run.** Assert `rst` at T+6.
  - Expect no `done` pulse, y=0, and all config cleared.
  - A following run with zero config gives y=0.
- **Back-to-back.** Assert `start` in the `done` cycle using the reference config.
  - Expect the second `done` at T+20, with y=3 both times and busy continuous from T+11.
